// File: rtl/board_fetch_arbiter_if.sv
// Video, game-writer and board-RAM signals of the board fetch arbiter.
// slave = arbiter side, master = surrounding system.
interface board_fetch_arbiter_if #(
  parameter int CELL_W = 3,
  parameter int ADDR_W = 9
);
  logic              line_start;
  logic [9:0]        line_y;
  logic              de;
  logic [4:0]        rd_col;
  logic [CELL_W-1:0] rd_cell;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [CELL_W-1:0] wr_data;
  logic              wr_gnt;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [CELL_W-1:0] ram_wdata;
  logic [CELL_W-1:0] ram_rdata;

  logic              fetch_busy;
  logic              overrun;

  modport slave (
    input  line_start, line_y, de, rd_col, wr_req, wr_addr, wr_data, ram_rdata,
    output rd_cell, wr_gnt, ram_addr, ram_we, ram_wdata, fetch_busy, overrun
  );

  modport master (
    output line_start, line_y, de, rd_col, wr_req, wr_addr, wr_data, ram_rdata,
    input  rd_cell, wr_gnt, ram_addr, ram_we, ram_wdata, fetch_busy, overrun
  );
endinterface

// File: rtl/board_fetch_arbiter.sv
// Board RAM arbiter: prefetches one cell row (COLS+1 clk) into a line buffer in hblank; game writes
// are granted combinationally in IDLE and stall (no gnt) while a fetch is in progress.
module board_fetch_arbiter #(
  parameter int COLS    = 20,
  parameter int ROWS    = 20,
  parameter int CELL_W  = 3,
  parameter int CELL_PX = 24,
  parameter int ADDR_W  = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  board_fetch_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [4:0] LAST_SUB = 5'(CELL_PX - 1);
  localparam logic [4:0] ROW_END  = 5'(ROWS);
  localparam logic [4:0] COL_END  = 5'(COLS);

  state_e            state_q, state_d;
  logic [4:0]        row_q, row_d;
  logic [4:0]        sub_q, sub_d;
  logic [4:0]        col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [CELL_W-1:0] lbuf_q [COLS];
  logic              de_q;
  logic              overrun_q;

  logic              trigger;
  logic              cap_en;
  logic [4:0]        cap_idx;
  logic [ADDR_W-1:0] row_base;

  // Row/sub-line tracking runs on every line_start, even while a fetch is busy.
  always_comb begin
    row_d = row_q;
    sub_d = sub_q;
    if (bus.line_start) begin
      if (bus.line_y == 10'd0) begin
        row_d = '0;
        sub_d = '0;
      end else if (sub_q == LAST_SUB) begin
        sub_d = '0;
        if (row_q != ROW_END) row_d = row_q + 5'd1;
      end else begin
        sub_d = sub_q + 5'd1;
      end
    end
  end

  assign trigger  = bus.line_start && (sub_d == 5'd0) && (row_d < ROW_END);
  assign row_base = (ADDR_W'(row_d) << 4) + (ADDR_W'(row_d) << 2);

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    base_d        = base_q;
    bus.ram_addr  = addr_hold_q;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.wr_gnt    = 1'b0;
    cap_en        = 1'b0;
    cap_idx       = col_q - 5'd1;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = FETCH;
          col_d   = '0;
          base_d  = row_base;
        end else if (bus.wr_req && rst_n) begin
          bus.ram_we    = 1'b1;
          bus.ram_addr  = bus.wr_addr;
          bus.ram_wdata = bus.wr_data;
          bus.wr_gnt    = 1'b1;
        end
      end
      FETCH: begin
        // Read data lags the address by one cycle, so column k lands while col_q == k+1.
        bus.ram_addr = base_q + ADDR_W'(col_q);
        col_d        = col_q + 5'd1;
        cap_en       = (col_q != 5'd0);
        if (col_q == LAST_COL) state_d = DRAIN;
      end
      DRAIN: begin
        cap_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      sub_q       <= '0;
      col_q       <= '0;
      base_q      <= '0;
      addr_hold_q <= '0;
      de_q        <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < COLS; i++) lbuf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      sub_q       <= sub_d;
      col_q       <= col_d;
      base_q      <= base_d;
      addr_hold_q <= bus.ram_addr;
      de_q        <= bus.de;
      if (bus.de && !de_q && (state_q != IDLE)) overrun_q <= 1'b1;
      if (cap_en) lbuf_q[cap_idx] <= bus.ram_rdata;
    end
  end

  assign bus.fetch_busy = (state_q != IDLE);
  assign bus.overrun    = overrun_q;
  assign bus.rd_cell    = (bus.rd_col < COL_END) ? lbuf_q[bus.rd_col] : '0;

endmodule

// File: tb/tb_board_fetch_arbiter.sv
// Directed bench for board_fetch_arbiter with a 1-cycle-latency board RAM model.
module tb_board_fetch_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  board_fetch_arbiter_if #(.CELL_W(3), .ADDR_W(9)) bus ();

  board_fetch_arbiter #(
    .COLS(20), .ROWS(20), .CELL_W(3), .CELL_PX(24), .ADDR_W(9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [2:0] mem [0:511];
  logic       pre_en = 1'b0;
  logic [8:0] pre_a  = '0;
  logic [2:0] pre_d  = '0;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    else if (pre_en) mem[pre_a] <= pre_d;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic start_fetch(input logic [9:0] y);
    bus.line_start = 1'b1;
    bus.line_y     = y;
    cyc();
    bus.line_start = 1'b0;
  endtask

  task automatic fetch_run(input string tag, input int base, input int de_at);
    #1;
    for (int i = 0; i < 21; i++) begin
      chk({tag, "_busy"}, bus.fetch_busy, 1);
      if (i < 20) chk({tag, "_addr"}, bus.ram_addr, base + i);
      chk({tag, "_we"}, bus.ram_we, 0);
      chk({tag, "_gnt"}, bus.wr_gnt, 0);
      if (de_at >= 0 && i > de_at) chk({tag, "_ovr"}, bus.overrun, 1);
      if (i == de_at) bus.de = 1'b1;
      cyc();
      #1;
    end
    chk({tag, "_done"}, bus.fetch_busy, 0);
  endtask

  task automatic check_row(input string tag, input int off, input bit patched);
    int e;
    for (int k = 0; k < 20; k++) begin
      bus.rd_col = 5'(k);
      #1;
      e = (k + off) % 8;
      if (patched && k == 5) e = 7;
      chk($sformatf("%s_cell%0d", tag, k), bus.rd_cell, e);
    end
  endtask

  task automatic check_clear(input string tag);
    for (int k = 0; k < 20; k++) begin
      bus.rd_col = 5'(k);
      #1;
      chk($sformatf("%s_clr%0d", tag, k), bus.rd_cell, 0);
    end
  endtask

  initial begin
    bus.line_start = 1'b0;
    bus.line_y     = '0;
    bus.de         = 1'b0;
    bus.rd_col     = '0;
    bus.wr_req     = 1'b1;
    bus.wr_addr    = 9'd9;
    bus.wr_data    = 3'd1;

    // Reset state, with a write already requested.
    #3;
    chk("rst_gnt",   bus.wr_gnt, 0);
    chk("rst_we",    bus.ram_we, 0);
    chk("rst_addr",  bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_busy",  bus.fetch_busy, 0);
    chk("rst_ovr",   bus.overrun, 0);
    check_clear("rst");
    bus.wr_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rel_busy", bus.fetch_busy, 0);
    chk("rel_gnt",  bus.wr_gnt, 0);

    // Row 0 = col%8, row 1 = (col+3)%8.
    for (int a = 0; a < 40; a++) begin
      cyc();
      pre_en = 1'b1;
      pre_a  = 9'(a);
      pre_d  = (a < 20) ? 3'(a % 8) : 3'((a - 20 + 3) % 8);
    end
    cyc();
    pre_en = 1'b0;

    // de rising while idle is not an overrun.
    bus.de = 1'b1;
    cyc();
    bus.de = 1'b0;
    cyc();
    chk("idle_de_ovr", bus.overrun, 0);

    // Row 0 fetch on line 0.
    start_fetch(10'd0);
    fetch_run("row0", 0, -1);
    chk("row0_hold", bus.ram_addr, 19);
    check_row("row0", 0, 0);
    bus.rd_col = 5'd20;
    #1;
    chk("col20", bus.rd_cell, 0);
    bus.rd_col = 5'd31;
    #1;
    chk("col31", bus.rd_cell, 0);

    // Row advance: only line 24 fires.
    for (int y = 1; y < 24; y++) begin
      start_fetch(10'(y));
      #1;
      chk($sformatf("noft_y%0d", y), bus.fetch_busy, 0);
      cyc();
    end
    start_fetch(10'd24);
    fetch_run("row1", 20, -1);
    check_row("row1", 3, 0);

    // Plain write in IDLE: granted same cycle, address held afterwards.
    cyc();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 9'd21;
    bus.wr_data = 3'd2;
    #1;
    chk("wr_gnt",   bus.wr_gnt, 1);
    chk("wr_we",    bus.ram_we, 1);
    chk("wr_addr",  bus.ram_addr, 21);
    chk("wr_wdata", bus.ram_wdata, 2);
    cyc();
    bus.wr_req = 1'b0;
    #1;
    chk("wr_gnt_off", bus.wr_gnt, 0);
    chk("wr_we_off",  bus.ram_we, 0);
    chk("wr_hold",    bus.ram_addr, 21);

    // Collision: fetch wins, write granted on first IDLE cycle.
    cyc();
    bus.wr_req     = 1'b1;
    bus.wr_addr    = 9'd5;
    bus.wr_data    = 3'd7;
    bus.line_start = 1'b1;
    bus.line_y     = 10'd0;
    #1;
    chk("coll_trig_gnt", bus.wr_gnt, 0);
    chk("coll_trig_we",  bus.ram_we, 0);
    cyc();
    bus.line_start = 1'b0;
    fetch_run("coll", 0, -1);
    chk("coll_gnt",   bus.wr_gnt, 1);
    chk("coll_we",    bus.ram_we, 1);
    chk("coll_addr",  bus.ram_addr, 5);
    chk("coll_wdata", bus.ram_wdata, 7);
    check_row("coll", 0, 0);
    cyc();
    bus.wr_req = 1'b0;
    #1;
    chk("coll_gnt_off", bus.wr_gnt, 0);

    // Overrun: de rises 10 clk into the fetch.
    cyc();
    chk("ovr_pre", bus.overrun, 0);
    start_fetch(10'd0);
    fetch_run("ovr", 0, 10);
    chk("ovr_after", bus.overrun, 1);
    check_row("ovr", 0, 1);
    bus.de = 1'b0;
    repeat (5) cyc();
    chk("ovr_sticky", bus.overrun, 1);

    // Mid-fetch reset at column 8 with a write pending.
    start_fetch(10'd0);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 9'd30;
    bus.wr_data = 3'd4;
    repeat (8) cyc();
    #1;
    chk("mid_col8", bus.ram_addr, 8);
    chk("mid_gnt_busy", bus.wr_gnt, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_we",   bus.ram_we, 0);
    chk("mid_gnt",  bus.wr_gnt, 0);
    chk("mid_busy", bus.fetch_busy, 0);
    chk("mid_addr", bus.ram_addr, 0);
    chk("mid_ovr",  bus.overrun, 0);
    check_clear("mid");
    rst_n = 1'b1;
    #1;
    chk("regnt_gnt",  bus.wr_gnt, 1);
    chk("regnt_addr", bus.ram_addr, 30);
    chk("regnt_data", bus.ram_wdata, 4);
    cyc();
    bus.wr_req = 1'b0;
    #1;
    chk("regnt_off", bus.wr_gnt, 0);
    start_fetch(10'd0);
    fetch_run("refetch", 0, -1);
    check_row("refetch", 0, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
